addr_sreg_ctr: RTL and testbench

//  Parametrised serial-load address register with auto-increment, successor to the 21-bit

---
 rtl/addr_sreg_ctr_if.sv | 25 ++
 rtl/addr_sreg_ctr.sv | 154 +++++++++++++++
 tb/tb_addr_sreg_ctr.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/addr_sreg_ctr_if.sv
// rtl/addr_sreg_ctr_if.sv - MCU serial pins and live address bus of addr_sreg_ctr
interface addr_sreg_ctr_if #(
  parameter int DWIDTH = 24
) ();
  logic              sdi;
  logic              shift_en_n;
  logic              load_n;
  logic              inc_n;
  logic [DWIDTH-1:0] out;
  logic              valid;
  logic              wrap;
  logic              err;
  logic              sdo;
  logic [7:0]        debug;

  modport master (
    output sdi, shift_en_n, load_n, inc_n,
    input  out, valid, wrap, err, sdo, debug
  );

  modport slave (
    input  sdi, shift_en_n, load_n, inc_n,
    output out, valid, wrap, err, sdo, debug
  );
endinterface

// File: rtl/addr_sreg_ctr.sv
// rtl/addr_sreg_ctr.sv - serial-load shadow address register with commit and auto-increment
// Optional serial readback of the live address is enabled by defining SREG_READBACK_EN.
module addr_sreg_ctr #(
  parameter int DWIDTH    = 24,
  parameter int CNT_STEP  = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  addr_sreg_ctr_if.slave bus
);

  localparam int              CW       = $clog2(DWIDTH + 1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(DWIDTH);
  localparam logic [DWIDTH:0] STEP     = (DWIDTH + 1)'(CNT_STEP);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FULL
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DWIDTH-1:0] r_shadow;
  logic [DWIDTH-1:0] w_shadow_nxt;
  logic [DWIDTH-1:0] w_shadow_shifted;
  logic [CW-1:0]     r_bit_cnt;
  logic [CW-1:0]     w_bit_cnt_nxt;
  logic [CW-1:0]     w_bit_cnt_inc;
  logic [DWIDTH-1:0] r_out;
  logic [DWIDTH-1:0] w_out_nxt;
  logic              r_valid;
  logic              w_valid_nxt;
  logic              r_wrap;
  logic              w_wrap_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic [DWIDTH:0]   w_sum;
  logic              w_shift;
  logic              w_load;
  logic              w_inc;

  assign w_shift       = ~bus.shift_en_n;
  assign w_load        = ~bus.load_n;
  assign w_inc         = ~bus.inc_n;
  assign w_bit_cnt_inc = r_bit_cnt + CW'(1);
  // Carry out of the extra top bit is the wrap indication only.
  assign w_sum         = {1'b0, r_out} + STEP;

  assign w_shadow_shifted = MSB_FIRST ? {r_shadow[DWIDTH-2:0], bus.sdi}
                                      : {bus.sdi, r_shadow[DWIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_shadow  <= '0;
      r_bit_cnt <= '0;
      r_out     <= '0;
      r_valid   <= 1'b0;
      r_wrap    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shadow  <= w_shadow_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_out     <= w_out_nxt;
      r_valid   <= w_valid_nxt;
      r_wrap    <= w_wrap_nxt;
      r_err     <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shadow_nxt  = r_shadow;
    w_bit_cnt_nxt = r_bit_cnt;
    w_out_nxt     = r_out;
    w_valid_nxt   = r_valid;
    w_wrap_nxt    = 1'b0;
    w_err_nxt     = r_err;

    if (w_load) begin
      // Commit sees the pre-shift state; a simultaneous shift bit and increment are dropped.
      w_state_nxt   = ST_IDLE;
      w_bit_cnt_nxt = '0;
      if (r_state == ST_FULL) begin
        w_out_nxt   = r_shadow;
        w_valid_nxt = 1'b1;
        w_err_nxt   = 1'b0;
      end else begin
        w_err_nxt    = 1'b1;
        w_shadow_nxt = '0;
      end
    end else begin
      if (w_shift) begin
        w_shadow_nxt = w_shadow_shifted;
        case (r_state)
          ST_IDLE: begin
            w_bit_cnt_nxt = CW'(1);
            w_state_nxt   = ST_SHIFT;
          end
          ST_SHIFT: begin
            w_bit_cnt_nxt = w_bit_cnt_inc;
            if (w_bit_cnt_inc == FULL_CNT) begin
              w_state_nxt = ST_FULL;
            end
          end
          ST_FULL: begin
            w_err_nxt = 1'b1;
          end
          default: begin
            w_state_nxt = ST_IDLE;
          end
        endcase
      end
      if (w_inc) begin
        w_out_nxt  = w_sum[DWIDTH-1:0];
        w_wrap_nxt = w_sum[DWIDTH];
      end
    end
  end

`ifdef SREG_READBACK_EN
  localparam logic [CW-1:0] LAST_IDX = CW'(DWIDTH - 1);

  logic [CW-1:0] w_rb_cnt;
  logic [CW-1:0] w_rb_idx;
  logic          r_sdo;

  // Once FULL the count sits at DWIDTH, so pin the index on the last bit.
  assign w_rb_cnt = (r_bit_cnt > LAST_IDX) ? LAST_IDX : r_bit_cnt;
  assign w_rb_idx = MSB_FIRST ? (LAST_IDX - w_rb_cnt) : w_rb_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sdo <= 1'b0;
    end else begin
      r_sdo <= w_shift & r_out[w_rb_idx];
    end
  end

  assign bus.sdo = r_sdo;
`else
  assign bus.sdo = 1'b0;
`endif

  assign bus.out   = r_out;
  assign bus.valid = r_valid;
  assign bus.wrap  = r_wrap;
  assign bus.err   = r_err;
  assign bus.debug = r_out[7:0];

endmodule

// File: tb/tb_addr_sreg_ctr.sv
// tb/tb_addr_sreg_ctr.sv - directed vector bench for addr_sreg_ctr (DWIDTH=24, CNT_STEP=1, MSB first)
module tb_addr_sreg_ctr;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  addr_sreg_ctr_if #(.DWIDTH(24)) bus ();

  addr_sreg_ctr #(
    .DWIDTH   (24),
    .CNT_STEP (1),
    .MSB_FIRST(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {OP_RST, OP_LOAD, OP_SHORT, OP_INC, OP_INCHOLD, OP_LDINC, OP_IDLE} op_e;

  typedef struct {
    op_e         op;
    logic [23:0] data;
    int          n;
    logic [23:0] exp_out;
    logic        exp_valid;
    logic        exp_wrap;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.sdi        = 1'b0;
    bus.shift_en_n = 1'b1;
    bus.load_n     = 1'b1;
    bus.inc_n      = 1'b1;
  endtask

  task automatic shift_bits(input logic [23:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      bus.sdi        = v[23-i];
      bus.shift_en_n = 1'b0;
      step();
    end
    bus.shift_en_n = 1'b1;
    bus.sdi        = 1'b0;
  endtask

  task automatic commit(input logic with_inc);
    bus.load_n = 1'b0;
    bus.inc_n  = ~with_inc;
    step();
    bus.load_n = 1'b1;
    bus.inc_n  = 1'b1;
  endtask

  task automatic hold_inc(input int n);
    bus.inc_n = 1'b0;
    for (int i = 0; i < n; i++) step();
    bus.inc_n = 1'b1;
  endtask

  task automatic chk_state(input string tag, input logic [23:0] o, input logic v,
                           input logic w, input logic e);
    chk({tag, "_out"}, 32'(bus.out), 32'(o));
    chk({tag, "_valid"}, 32'(bus.valid), 32'(v));
    chk({tag, "_wrap"}, 32'(bus.wrap), 32'(w));
    chk({tag, "_err"}, 32'(bus.err), 32'(e));
    chk({tag, "_debug"}, 32'(bus.debug), 32'(o[7:0]));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    idle_inputs();

    vecs.push_back('{OP_RST,     24'h000000, 0,  24'h000000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{OP_LOAD,    24'hC0FFEE, 24, 24'hC0FFEE, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{OP_LOAD,    24'hFFFFFE, 24, 24'hFFFFFE, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{OP_INC,     24'h000000, 0,  24'hFFFFFF, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{OP_INC,     24'h000000, 0,  24'h000000, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{OP_IDLE,    24'h000000, 0,  24'h000000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{OP_SHORT,   24'hABCDEF, 10, 24'h000000, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{OP_LOAD,    24'h000010, 24, 24'h000010, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{OP_INCHOLD, 24'h000000, 4,  24'h000014, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{OP_LDINC,   24'h0000AA, 24, 24'h0000AA, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{OP_SHORT,   24'h000000, 0,  24'h0000AA, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{OP_LOAD,    24'h800001, 24, 24'h800001, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{OP_RST,     24'h000000, 0,  24'h000000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{OP_INC,     24'h000000, 0,  24'h000001, 1'b0, 1'b0, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_RST:     begin rst_n = 1'b0; step(); rst_n = 1'b1; end
        OP_LOAD:    begin shift_bits(vecs[i].data, vecs[i].n); commit(1'b0); end
        OP_SHORT:   begin shift_bits(vecs[i].data, vecs[i].n); commit(1'b0); end
        OP_INC:     hold_inc(1);
        OP_INCHOLD: hold_inc(vecs[i].n);
        OP_LDINC:   begin shift_bits(vecs[i].data, vecs[i].n); commit(1'b1); end
        default:    step();
      endcase
      chk_state($sformatf("v%0d", i), vecs[i].exp_out, vecs[i].exp_valid,
                vecs[i].exp_wrap, vecs[i].exp_err);
    end

    // Held increment across the top: wrap only on the crossing cycle.
    shift_bits(24'hFFFFFD, 24);
    commit(1'b0);
    bus.inc_n = 1'b0;
    step(); chk_state("hold1", 24'hFFFFFE, 1'b1, 1'b0, 1'b0);
    step(); chk_state("hold2", 24'hFFFFFF, 1'b1, 1'b0, 1'b0);
    step(); chk_state("hold3", 24'h000000, 1'b1, 1'b1, 1'b0);
    step(); chk_state("hold4", 24'h000001, 1'b1, 1'b0, 1'b0);
    bus.inc_n = 1'b1;

    // Overrun: 25th bit sets err, shadow keeps the last 24 bits, good commit clears err.
    shift_bits(24'h5A5A5A, 24);
    bus.sdi = 1'b1; bus.shift_en_n = 1'b0;
    step();
    idle_inputs();
    chk_state("ovr", 24'h000001, 1'b1, 1'b0, 1'b1);
    commit(1'b0);
    chk_state("ovr_commit", 24'hB4B4B5, 1'b1, 1'b0, 1'b0);

    // Shift in the commit cycle is dropped; counter restarts so a bare commit is short.
    shift_bits(24'h123ABC, 24);
    bus.sdi = 1'b1; bus.shift_en_n = 1'b0; bus.load_n = 1'b0;
    step();
    idle_inputs();
    chk_state("ld_sh", 24'h123ABC, 1'b1, 1'b0, 1'b0);
    commit(1'b0);
    chk_state("ld_sh_again", 24'h123ABC, 1'b1, 1'b0, 1'b1);

    // Live address counts while the shadow fills.
    shift_bits(24'h000100, 24);
    commit(1'b0);
    bus.inc_n = 1'b0;
    shift_bits(24'h777777, 24);
    bus.inc_n = 1'b1;
    chk_state("inc_shift", 24'h000118, 1'b1, 1'b0, 1'b0);
    commit(1'b0);
    chk_state("inc_shift_commit", 24'h777777, 1'b1, 1'b0, 1'b0);

    // Reset mid-shift discards the partial shadow and bit count.
    shift_bits(24'hFFF000, 12);
    bus.shift_en_n = 1'b0; bus.sdi = 1'b1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle_inputs();
    chk_state("mid_rst", 24'h000000, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_sdo", 32'(bus.sdo), 32'h0);
    shift_bits(24'h123456, 24);
    commit(1'b0);
    chk_state("post_rst", 24'h123456, 1'b1, 1'b0, 1'b0);

    // Serial readback of the live address during a shift burst.
    begin
      logic [23:0] rb;
      rb = 24'hA5A5A5;
      shift_bits(rb, 24);
      commit(1'b0);
      chk_state("rb_load", rb, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 25; i++) begin
        bus.shift_en_n = 1'b0;
        bus.sdi        = 1'b0;
        step();
`ifdef SREG_READBACK_EN
        chk($sformatf("rb_sdo%0d", i), 32'(bus.sdo), 32'(rb[(i > 23) ? 0 : 23 - i]));
`else
        chk($sformatf("rb_sdo%0d", i), 32'(bus.sdo), 32'h0);
`endif
      end
      idle_inputs();
      step();
      chk("rb_sdo_idle", 32'(bus.sdo), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
